data_path_param: RTL and testbench
==================================

// Module: data_path_param
// PURPOSE
//  Parametrised CPU datapath: PC, MAR, IR, NREGS general registers, internal ALU and CCR.
//  Adds a memory read/write handshake with wait states, holding the datapath while memory is busy.
//  Sits between the control FSM and the memory block.
//  The control FSM issues one-cycle requests and sequences on Mem_Busy.
// PARAMETERS
//  DATA_W  8  width of data, registers, ALU and buses.
//  ADDR_W  8  width of PC, MAR and address; PC/MAR take Bus2[ADDR_W-1:0], zero-extended onto Bus1.
//  NREGS   4  number of general registers R0..R(NREGS-1); range 2..16.
//  SEL_W   $clog2(NREGS+1)  derived (localparam); width of Bus1_Sel and Reg_Dst.
// PORTS
//  Clk          in   1       clock, rising edge
//  Reset        in   1       asynchronous, active-high
//  Bus1_Sel     in   SEL_W   0=PC, k=R(k-1); values >NREGS drive Bus1 = 0
//  Bus2_Sel     in   2       0=ALU result, 1=Bus1, 2=MDR, 3=SP (or 0, see CONFIGURATION)
//  ALU_Sel      in   3       0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT A,6 INC A,7 DEC A
//  ALU_A_Sel    in   SEL_W   register index for ALU operand A (same map as Bus1_Sel)
//  ALU_B_Sel    in   SEL_W   register index for ALU operand B
//  IR_Load, MAR_Load, PC_Load, PC_Inc, Reg_Load, CCR_Load  in 1  load strobes
//  Reg_Dst      in   SEL_W   destination register for Reg_Load (1..NREGS; others ignored)
//  Mem_Rd_Req   in   1       start read at address=MAR
//  Mem_Wr_Req   in   1       start write of Bus1 to address=MAR
//  mem_ready    in   1       memory completes current access
//  from_memory  in   DATA_W  read data, valid when mem_ready=1
//  address      out  ADDR_W  = MAR
//  to_memory    out  DATA_W  write-data latch
//  mem_rd       out  1       read strobe, held until mem_ready
//  mem_wr       out  1       write strobe, held until mem_ready
//  Mem_Busy     out  1       access in progress
//  IR_out       out  DATA_W  instruction register
//  CCR_Result   out  4       NZVC flags
// BEHAVIOUR
//  - Reset: PC, MAR, IR, all R, MDR, to_memory, CCR = 0; mem_rd=mem_wr=Mem_Busy=0; FSM IDLE.
//  - Bus1/Bus2 and ALU are combinational; all registers update on rising Clk.
//  - PC: PC_Load has priority over PC_Inc; increment wraps 2^ADDR_W-1 -> 0.
//  - ALU: N=msb, Z=(res==0), V=signed overflow (ADD/SUB/INC/DEC, else 0), C=carry/borrow out
//    (ADD/INC carry, SUB/DEC borrow, else 0). Result truncated to DATA_W.
//  - Memory FSM IDLE/READ/WRITE:
//    IDLE + Mem_Rd_Req -> READ next cycle, mem_rd=1.
//    IDLE + Mem_Wr_Req -> WRITE next cycle, to_memory<=Bus1 latched at request, mem_wr=1.
//    Rd and Wr together: read wins, write is dropped.
//    READ + mem_ready -> MDR<=from_memory, IDLE. WRITE + mem_ready -> IDLE.
//    Strobes deassert in the cycle after mem_ready is sampled.
//    Minimum access 2 cycles (request, ready) when mem_ready is held high.
//    Mem_Busy = (state != IDLE).
//  - While Mem_Busy=1: every load/inc strobe and new request is ignored.
//    MAR is frozen, so address stays stable for the whole access.
//  - Reset mid-access: strobes drop immediately (async); MDR is not updated.
// CONFIGURATION
//  DATA_PATH_SP_EN defined:
//    - Adds ports SP_Inc, SP_Dec, SP_Load (in, 1) and SP register (ADDR_W), reset to all-ones.
//    - SP_Load<=Bus2; priority Load > Dec > Inc; wraps both directions.
//    - Bus2_Sel=3 reads SP zero-extended. Same Mem_Busy gating as the other registers.
//  DATA_PATH_SP_EN undefined: no SP ports or register; Bus2_Sel=3 drives 0.
// TESTING (DATA_W=8, ADDR_W=8, NREGS=4)
//  1 Reset mid-READ -> mem_rd=0 async, all outputs 0, MDR unchanged=0.
//  2 R0=0x7F, R1=0x01, ALU ADD, Reg_Load Dst=3, CCR_Load -> R2=0x80, CCR=1010 (N,V).
//  3 MAR=0x10, Mem_Rd_Req, mem_ready low 3 cycles -> mem_rd/Mem_Busy high 3 cycles,
//    MDR=from_memory(0xA5) after ready; PC_Inc during busy has no effect.
//  4 Bus1=R3=0x3C, Mem_Wr_Req, change R3 next cycle -> to_memory stays 0x3C until ready.
//  5 PC=0xFF, PC_Inc -> PC=0x00; PC_Load+PC_Inc with Bus2=0x42 -> PC=0x42.
//  6 SP_EN: after reset SP=0xFF; SP_Inc -> 0x00; SP_Dec -> 0xFF; Bus2_Sel=3 reads SP.
//    SP_EN off: Bus2_Sel=3 reads 0.

Source files
------------

// File: rtl/data_path_param.sv
// rtl/data_path_param.sv - parametrised CPU datapath with memory handshake; optional stack pointer under DATA_PATH_SP_EN
module data_path_param #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int NREGS  = 4,
    localparam int SEL_W  = $clog2(NREGS + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [SEL_W-1:0]  Bus1_Sel,
    input  logic [1:0]        Bus2_Sel,
    input  logic [2:0]        ALU_Sel,
    input  logic [SEL_W-1:0]  ALU_A_Sel,
    input  logic [SEL_W-1:0]  ALU_B_Sel,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              PC_Inc,
    input  logic              Reg_Load,
    input  logic              CCR_Load,
    input  logic [SEL_W-1:0]  Reg_Dst,
`ifdef DATA_PATH_SP_EN
    input  logic              SP_Inc,
    input  logic              SP_Dec,
    input  logic              SP_Load,
`endif
    input  logic              Mem_Rd_Req,
    input  logic              Mem_Wr_Req,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] from_memory,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] to_memory,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              Mem_Busy,
    output logic [DATA_W-1:0] IR_out,
    output logic [3:0]        CCR_Result
);

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} mem_state_t;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, mar_q;
    logic [DATA_W-1:0] ir_q, mdr_q, to_mem_q;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [3:0]        ccr_q;
    logic [DATA_W-1:0] bus1, bus2, alu_a, alu_b, alu_res;
    logic [DATA_W:0]   alu_ext;
    logic              alu_v, alu_c;
    logic              idle;
`ifdef DATA_PATH_SP_EN
    logic [ADDR_W-1:0] sp_q;
`endif

    // Everything architectural is frozen while an access is outstanding
    assign idle       = (state_q == S_IDLE);
    assign Mem_Busy   = !idle;
    assign mem_rd     = (state_q == S_READ);
    assign mem_wr     = (state_q == S_WRITE);
    assign address    = mar_q;
    assign to_memory  = to_mem_q;
    assign IR_out     = ir_q;
    assign CCR_Result = ccr_q;

    // Register-file read ports: index 0 is PC, k is R(k-1), out-of-range reads 0
    always_comb begin
        bus1  = '0;
        alu_a = '0;
        alu_b = '0;
        if (Bus1_Sel == '0)  bus1  = DATA_W'(pc_q);
        if (ALU_A_Sel == '0) alu_a = DATA_W'(pc_q);
        if (ALU_B_Sel == '0) alu_b = DATA_W'(pc_q);
        for (int i = 0; i < NREGS; i++) begin
            if (Bus1_Sel == SEL_W'(i + 1))  bus1  = regs_q[i];
            if (ALU_A_Sel == SEL_W'(i + 1)) alu_a = regs_q[i];
            if (ALU_B_Sel == SEL_W'(i + 1)) alu_b = regs_q[i];
        end
    end

    // ALU with NZVC; INC/DEC reuse the add/subtract paths with a constant one
    always_comb begin
        alu_ext = '0;
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (ALU_Sel)
            3'd0, 3'd6: begin
                alu_ext = {1'b0, alu_a} + {1'b0, (ALU_Sel == 3'd0) ? alu_b : ONE};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (alu_a[MSB] == ((ALU_Sel == 3'd0) ? alu_b[MSB] : 1'b0))
                          && (alu_res[MSB] != alu_a[MSB]);
            end
            3'd1, 3'd7: begin
                alu_ext = {1'b0, alu_a} - {1'b0, (ALU_Sel == 3'd1) ? alu_b : ONE};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (alu_a[MSB] != ((ALU_Sel == 3'd1) ? alu_b[MSB] : 1'b0))
                          && (alu_res[MSB] != alu_a[MSB]);
            end
            3'd2:    alu_res = alu_a & alu_b;
            3'd3:    alu_res = alu_a | alu_b;
            3'd4:    alu_res = alu_a ^ alu_b;
            default: alu_res = ~alu_a;
        endcase
    end

    // Bus2 source mux; slot 3 is the stack pointer when present
    always_comb begin
        bus2 = '0;
        case (Bus2_Sel)
            2'd0:    bus2 = alu_res;
            2'd1:    bus2 = bus1;
            2'd2:    bus2 = mdr_q;
`ifdef DATA_PATH_SP_EN
            default: bus2 = DATA_W'(sp_q);
`else
            default: bus2 = '0;
`endif
        endcase
    end

    // Memory handshake next state; a simultaneous write request loses to the read
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (Mem_Rd_Req)      state_d = S_READ;
                else if (Mem_Wr_Req) state_d = S_WRITE;
            end
            S_READ:  if (mem_ready) state_d = S_IDLE;
            S_WRITE: if (mem_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory handshake state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Architectural registers; loads only land while idle, MDR only on read completion
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q     <= '0;
            mar_q    <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            to_mem_q <= '0;
            ccr_q    <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (state_q == S_READ && mem_ready) mdr_q <= from_memory;
            if (idle) begin
                if (PC_Load)     pc_q  <= ADDR_W'(bus2);
                else if (PC_Inc) pc_q  <= pc_q + ADDR_W'(1);
                if (MAR_Load)    mar_q <= ADDR_W'(bus2);
                if (IR_Load)     ir_q  <= bus2;
                if (CCR_Load)    ccr_q <= {alu_res[MSB], (alu_res == '0), alu_v, alu_c};
                if (Reg_Load) begin
                    for (int i = 0; i < NREGS; i++)
                        if (Reg_Dst == SEL_W'(i + 1)) regs_q[i] <= bus2;
                end
                if (Mem_Wr_Req && !Mem_Rd_Req) to_mem_q <= bus1;
            end
        end
    end

`ifdef DATA_PATH_SP_EN
    // Stack pointer: load beats decrement beats increment, wrapping both ways
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) sp_q <= '1;
        else if (idle) begin
            if (SP_Load)     sp_q <= ADDR_W'(bus2);
            else if (SP_Dec) sp_q <= sp_q - ADDR_W'(1);
            else if (SP_Inc) sp_q <= sp_q + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_data_path_param.sv
// tb/tb_data_path_param.sv - directed self-checking bench for data_path_param
module tb_data_path_param;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] Bus1_Sel, ALU_A_Sel, ALU_B_Sel, Reg_Dst;
    logic [1:0] Bus2_Sel;
    logic [2:0] ALU_Sel;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, Reg_Load, CCR_Load;
    logic       SP_Inc, SP_Dec, SP_Load;
    logic       Mem_Rd_Req, Mem_Wr_Req, mem_ready;
    logic [7:0] from_memory;
    logic [7:0] address, to_memory, IR_out;
    logic       mem_rd, mem_wr, Mem_Busy;
    logic [3:0] CCR_Result;

    int total = 0;
    int bad   = 0;

    data_path_param #(.DATA_W(8), .ADDR_W(8), .NREGS(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .ALU_Sel(ALU_Sel),
        .ALU_A_Sel(ALU_A_Sel), .ALU_B_Sel(ALU_B_Sel),
        .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
        .Reg_Load(Reg_Load), .CCR_Load(CCR_Load), .Reg_Dst(Reg_Dst),
`ifdef DATA_PATH_SP_EN
        .SP_Inc(SP_Inc), .SP_Dec(SP_Dec), .SP_Load(SP_Load),
`endif
        .Mem_Rd_Req(Mem_Rd_Req), .Mem_Wr_Req(Mem_Wr_Req), .mem_ready(mem_ready),
        .from_memory(from_memory), .address(address), .to_memory(to_memory),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .Mem_Busy(Mem_Busy),
        .IR_out(IR_out), .CCR_Result(CCR_Result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear();
        Bus1_Sel = 0; Bus2_Sel = 0; ALU_Sel = 0; ALU_A_Sel = 0; ALU_B_Sel = 0; Reg_Dst = 0;
        IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0; Reg_Load = 0; CCR_Load = 0;
        SP_Inc = 0; SP_Dec = 0; SP_Load = 0;
        Mem_Rd_Req = 0; Mem_Wr_Req = 0; mem_ready = 0;
    endtask

    // Zero-wait read of the current MAR, leaving val in MDR
    task automatic load_mdr(input logic [7:0] val);
        clear();
        Mem_Rd_Req = 1;
        tick();
        Mem_Rd_Req = 0; mem_ready = 1; from_memory = val;
        tick();
        mem_ready = 0;
    endtask

    task automatic load_reg(input logic [2:0] dst, input logic [7:0] val);
        load_mdr(val);
        Bus2_Sel = 2; Reg_Load = 1; Reg_Dst = dst;
        tick();
        clear();
    endtask

    // Copy a Bus2 source into IR so it becomes observable
    task automatic peek(input logic [2:0] b1, input logic [1:0] b2);
        clear();
        Bus1_Sel = b1; Bus2_Sel = b2; IR_Load = 1;
        tick();
        clear();
    endtask

    typedef struct {
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [7:0] res;
        logic [3:0] ccr;
    } alu_vec_t;

    // R0=7F, R1=01, R2=00, R3=FF during the table
    alu_vec_t alu_tab [11] = '{
        '{3'd0, 3'd1, 3'd2, 8'h80, 4'b1010},
        '{3'd1, 3'd1, 3'd2, 8'h7E, 4'b0000},
        '{3'd1, 3'd2, 3'd1, 8'h82, 4'b1001},
        '{3'd2, 3'd1, 3'd2, 8'h01, 4'b0000},
        '{3'd3, 3'd1, 3'd2, 8'h7F, 4'b0000},
        '{3'd4, 3'd1, 3'd1, 8'h00, 4'b0100},
        '{3'd5, 3'd1, 3'd2, 8'h80, 4'b1000},
        '{3'd6, 3'd1, 3'd2, 8'h80, 4'b1010},
        '{3'd7, 3'd1, 3'd2, 8'h7E, 4'b0000},
        '{3'd7, 3'd3, 3'd2, 8'hFF, 4'b1001},
        '{3'd6, 3'd4, 3'd2, 8'h00, 4'b0101}
    };

    initial begin
        clear();
        from_memory = 8'h00;
        Reset = 1;
        tick(); tick();
        Reset = 0;

        check("rst_addr", address, 8'h00);
        check("rst_tomem", to_memory, 8'h00);
        check("rst_strobes", {mem_rd, mem_wr, Mem_Busy}, 3'b000);
        check("rst_ir", IR_out, 8'h00);
        check("rst_ccr", CCR_Result, 4'h0);

        // Reset in the middle of a read
        from_memory = 8'h5A;
        Mem_Rd_Req = 1;
        tick();
        Mem_Rd_Req = 0;
        check("midrd_rd", mem_rd, 1'b1);
        Reset = 1;
        #1;
        check("midrd_async", {mem_rd, Mem_Busy}, 2'b00);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        Reset = 0;
        peek(3'd0, 2'd2);
        check("midrd_mdr", IR_out, 8'h00);

        // ALU and flags
        load_reg(3'd1, 8'h7F);
        load_reg(3'd2, 8'h01);
        load_reg(3'd3, 8'h00);
        load_reg(3'd4, 8'hFF);
        ALU_A_Sel = 1; ALU_B_Sel = 2; ALU_Sel = 0; Bus2_Sel = 0;
        Reg_Load = 1; Reg_Dst = 3; CCR_Load = 1;
        tick();
        clear();
        check("add_ccr", CCR_Result, 4'b1010);
        peek(3'd3, 2'd1);
        check("add_r2", IR_out, 8'h80);
        load_reg(3'd3, 8'h00);
        foreach (alu_tab[i]) begin
            clear();
            ALU_Sel = alu_tab[i].op; ALU_A_Sel = alu_tab[i].a; ALU_B_Sel = alu_tab[i].b;
            Bus2_Sel = 0; IR_Load = 1; CCR_Load = 1;
            tick();
            check($sformatf("alu%0d_res", i), IR_out, alu_tab[i].res);
            check($sformatf("alu%0d_ccr", i), CCR_Result, alu_tab[i].ccr);
        end

        // Read with three wait states; PC and MAR must stay put while busy
        load_mdr(8'h10);
        Bus2_Sel = 2; MAR_Load = 1;
        tick();
        clear();
        check("mar_load", address, 8'h10);
        Mem_Rd_Req = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            clear();
            PC_Inc = 1; MAR_Load = 1; Bus2_Sel = 1; Bus1_Sel = 1;
            check($sformatf("wait%0d_busy", k), {mem_rd, Mem_Busy, mem_wr}, 3'b110);
            check($sformatf("wait%0d_addr", k), address, 8'h10);
            tick();
        end
        clear();
        check("ready_cyc_busy", Mem_Busy, 1'b1);
        mem_ready = 1; from_memory = 8'hA5;
        tick();
        clear();
        check("rd_done", {mem_rd, Mem_Busy}, 2'b00);
        check("rd_addr", address, 8'h10);
        peek(3'd0, 2'd2);
        check("rd_mdr", IR_out, 8'hA5);
        peek(3'd0, 2'd1);
        check("busy_pc", IR_out, 8'h00);

        // Write data is captured at request time
        load_reg(3'd4, 8'h3C);
        Bus1_Sel = 4; Mem_Wr_Req = 1;
        tick();
        clear();
        check("wr_strobe", {mem_wr, mem_rd, Mem_Busy}, 3'b101);
        check("wr_data", to_memory, 8'h3C);
        Bus1_Sel = 1; Bus2_Sel = 1; Reg_Load = 1; Reg_Dst = 4; Mem_Wr_Req = 1;
        tick();
        clear();
        check("wr_hold", to_memory, 8'h3C);
        mem_ready = 1;
        tick();
        clear();
        check("wr_done", {mem_wr, Mem_Busy}, 2'b00);
        peek(3'd4, 2'd1);
        check("wr_r3_kept", IR_out, 8'h3C);
        load_reg(3'd4, 8'h11);
        check("wr_latch", to_memory, 8'h3C);

        // Read beats write when both are requested
        Bus1_Sel = 4; Mem_Rd_Req = 1; Mem_Wr_Req = 1;
        tick();
        clear();
        check("rdwr_strobes", {mem_rd, mem_wr}, 2'b10);
        mem_ready = 1; from_memory = 8'h77;
        tick();
        clear();
        check("rdwr_dropped", to_memory, 8'h3C);

        // PC wrap and load-over-increment priority
        load_mdr(8'hFF);
        Bus2_Sel = 2; PC_Load = 1;
        tick();
        clear();
        PC_Inc = 1;
        tick();
        peek(3'd0, 2'd1);
        check("pc_wrap", IR_out, 8'h00);
        load_mdr(8'h42);
        Bus2_Sel = 2; PC_Load = 1; PC_Inc = 1;
        tick();
        peek(3'd0, 2'd1);
        check("pc_load_prio", IR_out, 8'h42);
        peek(3'd5, 2'd1);
        check("bus1_oor", IR_out, 8'h00);
        peek(3'd0, 2'd1);

`ifdef DATA_PATH_SP_EN
        peek(3'd0, 2'd3);
        check("sp_reset", IR_out, 8'hFF);
        SP_Inc = 1;
        tick();
        peek(3'd0, 2'd3);
        check("sp_inc_wrap", IR_out, 8'h00);
        SP_Dec = 1; SP_Inc = 1;
        tick();
        peek(3'd0, 2'd3);
        check("sp_dec_wrap", IR_out, 8'hFF);
`else
        peek(3'd0, 2'd3);
        check("bus2_sel3", IR_out, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
